// File: rtl/add_responder.sv
// Operand/sum responder: registers (a,b), writes a+b into an in-order result FIFO, returns sums.
// Optional per-entry parity output y_par is enabled by defining ADD_RESP_PARITY_EN.
module add_responder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
`ifdef ADD_RESP_PARITY_EN
  output logic             y_par,
`endif
  output logic [15:0]      txn_count
);

  // Handshakes: a transfer happens on a posedge where valid && ready. in_ready
  // depends only on registered state; out_valid never drops without a pop.

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             stage_v_q, stage_v_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH:0]   y_last_q, y_last_d;
  logic [15:0]      txn_q, txn_d;
  logic [WIDTH:0]   sum;
  logic [AW+1:0]    occupancy;
  logic             accept, push, pop;

  assign occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, stage_v_q};
  assign in_ready  = occupancy < (AW+2)'(DEPTH);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = stage_v_q;
  assign pop       = out_valid && out_ready;
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  // When empty the head slot may hold stale data, so show the last popped value.
  assign y         = out_valid ? mem_q[rd_ptr_q] : y_last_q;
  assign txn_count = txn_q;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    stage_v_d = accept;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    y_last_d  = y_last_q;
    txn_d     = txn_q;
    if (accept) begin
      a_d = a;
      b_d = b;
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      y_last_d = mem_q[rd_ptr_q];
      txn_d    = txn_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      stage_v_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      y_last_q  <= '0;
      txn_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      stage_v_q <= stage_v_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      y_last_q  <= y_last_d;
      txn_q     <= txn_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= sum;
    end
  end

`ifdef ADD_RESP_PARITY_EN
  logic par_mem_q [DEPTH];
  logic par_last_q, par_last_d;

  assign y_par = out_valid ? par_mem_q[rd_ptr_q] : par_last_q;

  always_comb begin
    par_last_d = par_last_q;
    if (pop) par_last_d = par_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) par_mem_q[i] <= 1'b0;
      par_last_q <= 1'b0;
    end else begin
      par_last_q <= par_last_d;
      if (push) par_mem_q[wr_ptr_q] <= ^sum;
    end
  end
`endif

endmodule

// File: tb/tb_add_responder.sv
// Self-checking bench for add_responder: scoreboard queue filled on accept, drained on output.
module tb_add_responder;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   y;
  logic [15:0]  txn_count;
`ifdef ADD_RESP_PARITY_EN
  logic         y_par;
`endif

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];
  logic [W:0] exp_v;

  add_responder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef ADD_RESP_PARITY_EN
    .y_par     (y_par),
`endif
    .txn_count (txn_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs only change #1 after posedge, so the negedge sees what the next posedge will.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("y", 32'(y), 32'(exp_v));
`ifdef ADD_RESP_PARITY_EN
          check("y_par", 32'(y_par), 32'(^exp_v));
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back({1'b0, a} + {1'b0, b});
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
    int n;
    n = 0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [W:0] first_sum;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // basic sums and two-edge latency
    out_ready = 1'b1;
    send(4'd1, 4'd3);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_y4", 32'(y), 32'd4);
    send(4'd5, 4'd6);
    send(4'd7, 4'd8);
    drain();
    check("txn_3", 32'(txn_count), 32'd3);

    // no truncation
    send(4'd15, 4'd15);
    tick(1);
    check("y_30", 32'(y), 32'd30);
    drain();

    // fill with consumer stalled, hold, then release
    out_ready = 1'b0;
    first_sum = 5'd9 + 5'd4;
    send(4'd9, 4'd4);
    send(4'd2, 4'd12);
    send(4'd11, 4'd1);
    send(4'd6, 4'd6);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick(3);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_y", 32'(y), 32'(first_sum));
    check("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    check("pre_pop_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    check("post_pop_in_ready", 32'(in_ready), 32'd1);
    drain();

    // at full, stream 11 random pairs with consumer always ready
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    tick(2);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    drain();
    check("txn_stream", 32'(txn_count), 32'(3 + 1 + 4 + D + 11));

    // reset mid-operation with entries queued
    out_ready = 1'b0;
    send(4'd3, 4'd3);
    send(4'd4, 4'd4);
    send(4'd5, 4'd5);
    tick(2);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_txn", 32'(txn_count), 32'd0);
    check("async_rst_y", 32'(y), 32'd0);
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_y", 32'(y), 32'd0);
    send(4'd10, 4'd2);
    drain();
    check("post_rst_txn", 32'(txn_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
